// File: rtl/bb_shift_pkg.sv
// Shared constants and per-stage control payload for the pipelined barrel shifter.
package bb_shift_pkg;

  localparam logic [1:0] MODE_LSL_LSR = 2'b00;
  localparam logic [1:0] MODE_ASR     = 2'b01;
  localparam logic [1:0] MODE_ROT     = 2'b10;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Width-independent part of the stage payload; data and shift ride beside it.
  typedef struct packed {
    logic       dir;
    logic [1:0] mode;
    logic       sign;
    logic       carry;
  } shift_ctrl_t;

endpackage

// File: rtl/bb_shift_stage.sv
// One log-stage of the shifter: conditional 2^K shift, carry update and an
// elastic register slot with valid/ready.
module bb_shift_stage
  import bb_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int K     = 0,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_data,
  input  logic [SHW-1:0]   src_shift,
  input  shift_ctrl_t      src_ctrl,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] dst_data,
  output logic [SHW-1:0]   dst_shift,
  output shift_ctrl_t      dst_ctrl
);

  localparam int AMT = 1 << K;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   shift;
    shift_ctrl_t      ctrl;
  } payload_t;

  payload_t nxt;
  payload_t cur;
  logic     valid_q;

  always_comb begin
    nxt.data  = src_data;
    nxt.shift = src_shift;
    nxt.ctrl  = src_ctrl;
    if (src_shift[K]) begin
      if (src_ctrl.dir == DIR_LEFT) begin
        nxt.ctrl.carry = src_data[WIDTH-AMT];
        if (src_ctrl.mode == MODE_ROT)
          nxt.data = {src_data[WIDTH-AMT-1:0], src_data[WIDTH-1:WIDTH-AMT]};
        else
          nxt.data = {src_data[WIDTH-AMT-1:0], {AMT{1'b0}}};
      end else begin
        nxt.ctrl.carry = src_data[AMT-1];
        case (src_ctrl.mode)
          MODE_ROT: nxt.data = {src_data[AMT-1:0], src_data[WIDTH-1:AMT]};
          // sign was captured from the original operand, not this stage's input
          MODE_ASR: nxt.data = {{AMT{src_ctrl.sign}}, src_data[WIDTH-1:AMT]};
          default:  nxt.data = {{AMT{1'b0}}, src_data[WIDTH-1:AMT]};
        endcase
      end
    end
  end

  assign src_ready = !valid_q || dst_ready;

  // Stage register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid_q <= 1'b0;
    else if (flush)
      valid_q <= 1'b0;
    else if (src_ready)
      valid_q <= src_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cur <= '0;
    else if (src_valid && src_ready && !flush)
      cur <= nxt;
  end

  assign dst_valid = valid_q;
  assign dst_data  = cur.data;
  assign dst_shift = cur.shift;
  assign dst_ctrl  = cur.ctrl;

endmodule

// File: rtl/bb_shifter_pipe.sv
// Pipelined barrel shifter: SHW elastic log-stages, logical/arithmetic/rotate
// in both directions, with carry-out and zero flags.
module bb_shifter_pipe
  import bb_shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  // Index k is the input side of stage k; index SHW is the pipeline output.
  logic        [SHW:0]            valid_c;
  logic        [SHW:0]            ready_c;
  logic        [SHW:0][WIDTH-1:0] data_c;
  logic        [SHW:0][SHW-1:0]   shift_c;
  shift_ctrl_t [SHW:0]            ctrl_c;

  assign valid_c[0]       = in_valid;
  assign data_c[0]        = in_data;
  assign shift_c[0]       = in_shift;
  assign ctrl_c[0].dir    = in_dir;
  assign ctrl_c[0].mode   = in_mode;
  assign ctrl_c[0].sign   = in_data[WIDTH-1];
  assign ctrl_c[0].carry  = 1'b0;
  assign ready_c[SHW]     = out_ready;

  // A flush drops whatever is offered, so the input side always looks open.
  assign in_ready = ready_c[0] || flush;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    bb_shift_stage #(
      .WIDTH (WIDTH),
      .K     (k),
      .SHW   (SHW)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .src_valid (valid_c[k]),
      .src_ready (ready_c[k]),
      .src_data  (data_c[k]),
      .src_shift (shift_c[k]),
      .src_ctrl  (ctrl_c[k]),
      .dst_valid (valid_c[k+1]),
      .dst_ready (ready_c[k+1]),
      .dst_data  (data_c[k+1]),
      .dst_shift (shift_c[k+1]),
      .dst_ctrl  (ctrl_c[k+1])
    );
  end

  assign out_valid = valid_c[SHW];
  assign out_data  = data_c[SHW];
  assign out_carry = ctrl_c[SHW].carry;
  assign out_zero  = (data_c[SHW] == '0);

  logic unused_tail;
  assign unused_tail = ^{shift_c[SHW], ctrl_c[SHW].dir, ctrl_c[SHW].mode, ctrl_c[SHW].sign};

endmodule

// File: tb/tb_bb_shifter_pipe.sv
// Randomised, self-checking bench for bb_shifter_pipe (WIDTH = 8) against an
// arithmetic reference model and an in-flight operation queue.
module tb_bb_shifter_pipe;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_shift = '0;
  logic          in_dir = 1'b0;
  logic [1:0]    in_mode = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          out_carry;
  logic          out_zero;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Entries are {zero, carry, data}.
  logic [W+1:0] pend_q[$];
  int           pend_cyc[$];
  logic [W+1:0] got_q[$];
  logic [W+1:0] want_q[$];
  int           lat_q[$];
  int           got_cyc_q[$];
  logic         accepted;
  int           n_acc;

  bb_shifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] ref_op(input logic [W-1:0] d, input int s,
                                          input logic dir, input logic [1:0] mode);
    logic [W-1:0] r;
    logic         c;
    if (s == 0) begin
      r = d;
      c = 1'b0;
    end else if (!dir) begin
      c = d[W-s];
      if (mode == 2'b10) r = (d << s) | (d >> (W - s));
      else               r = d << s;
    end else begin
      c = d[s-1];
      if (mode == 2'b10)      r = (d >> s) | (d << (W - s));
      else if (mode == 2'b01) r = W'($signed(d) >>> s);
      else                    r = d >> s;
    end
    return {(r == '0), c, r};
  endfunction

  task automatic step();
    @(negedge clk);
    accepted = 1'b0;
    if (out_valid && out_ready) begin
      got_q.push_back({out_zero, out_carry, out_data});
      got_cyc_q.push_back(cyc);
      if (pend_q.size() > 0) begin
        want_q.push_back(pend_q.pop_front());
        lat_q.push_back(cyc - pend_cyc.pop_front());
      end else begin
        want_q.push_back('x);
        lat_q.push_back(-1);
      end
    end
    if (flush) begin
      pend_q.delete();
      pend_cyc.delete();
    end else if (in_valid && in_ready) begin
      pend_q.push_back(ref_op(in_data, int'(in_shift), in_dir, in_mode));
      pend_cyc.push_back(cyc);
      accepted = 1'b1;
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && pend_q.size() > 0; i++) step();
  endtask

  task automatic clear_log();
    got_q.delete();
    want_q.delete();
    lat_q.delete();
    got_cyc_q.delete();
    n_acc = 0;
  endtask

  task automatic rand_op();
    in_data  = W'($urandom);
    in_shift = SW'($urandom_range(0, 7));
    in_dir   = 1'($urandom_range(0, 1));
    in_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin n_errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    if (out_carry !== 1'b0) begin n_errors++; $display("FAIL reset_carry: got %b want 0", out_carry); end
    if (out_zero !== 1'b1) begin n_errors++; $display("FAIL reset_zero: got %b want 1", out_zero); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0]  dv[4] = '{8'h40, 8'h80, 8'h81, 8'h01};
    logic [SW-1:0] sv[4] = '{3'd1, 3'd3, 3'd1, 3'd1};
    logic          rv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]    mv[4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic [W-1:0]  ev[4] = '{8'h80, 8'hF0, 8'h03, 8'h00};
    logic          cv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic          zv[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_log();
      in_data = dv[i]; in_shift = sv[i]; in_dir = rv[i]; in_mode = mv[i];
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      drain(10);
      n_checks += 5;
      if (got_q.size() != 1) begin n_errors++; $display("FAIL dir%0d_count: got %0d want 1", i, got_q.size()); end
      if (got_q[0][W-1:0] !== ev[i]) begin n_errors++; $display("FAIL dir%0d_data: got %h want %h", i, got_q[0][W-1:0], ev[i]); end
      if (got_q[0][W] !== cv[i]) begin n_errors++; $display("FAIL dir%0d_carry: got %b want %b", i, got_q[0][W], cv[i]); end
      if (got_q[0][W+1] !== zv[i]) begin n_errors++; $display("FAIL dir%0d_zero: got %b want %b", i, got_q[0][W+1], zv[i]); end
      if (lat_q[0] != SW) begin n_errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat_q[0], SW); end
    end
  endtask

  task automatic test_stream();
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rand_op();
      in_valid = 1'b1;
      step();
      n_checks++;
      if (!accepted) begin n_errors++; $display("FAIL stream_accept%0d: got 0 want 1", i); end
    end
    in_valid = 1'b0;
    drain(12);
    n_checks++;
    if (got_q.size() != 16) begin n_errors++; $display("FAIL stream_count: got %0d want 16", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks += 2;
      if (got_q[i] !== want_q[i]) begin n_errors++; $display("FAIL stream_res%0d: got %h want %h", i, got_q[i], want_q[i]); end
      if (lat_q[i] != SW) begin n_errors++; $display("FAIL stream_lat%0d: got %0d want %0d", i, lat_q[i], SW); end
      if (i > 0) begin
        n_checks++;
        if (got_cyc_q[i] - got_cyc_q[i-1] != 1) begin
          n_errors++; $display("FAIL stream_gap%0d: got %0d want 1", i, got_cyc_q[i] - got_cyc_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] snap;
    logic         seen_full;
    clear_log();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op();
      in_valid = 1'b1;
      step();
    end
    out_ready = 1'b0;
    rand_op();
    seen_full = 1'b0;
    snap = {out_zero, out_carry, out_data};
    for (int i = 0; i < 5; i++) begin
      if (!in_ready) seen_full = 1'b1;
      step();
      if (accepted) rand_op();
      n_checks += 2;
      if (out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid%0d: got %b want 1", i, out_valid); end
      if ({out_zero, out_carry, out_data} !== snap) begin
        n_errors++; $display("FAIL bp_stable%0d: got %h want %h", i, {out_zero, out_carry, out_data}, snap);
      end
    end
    n_checks++;
    if (!seen_full) begin n_errors++; $display("FAIL bp_in_ready_low: got 1 want 0"); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (accepted) rand_op();
    end
    in_valid = 1'b0;
    drain(15);
    n_checks++;
    if (got_q.size() != n_acc) begin n_errors++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), n_acc); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== want_q[i]) begin n_errors++; $display("FAIL bp_res%0d: got %h want %h", i, got_q[i], want_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    clear_log();
    out_ready = 1'b0;
    in_data = 8'h3C; in_shift = 3'd2; in_dir = 1'b0; in_mode = 2'b00;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
    if (out_data !== 8'hF0) begin n_errors++; $display("FAIL ar_pre_data: got %h want f0", out_data); end
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin n_errors++; $display("FAIL ar_data: got %h want 00", out_data); end
    if (out_zero !== 1'b1) begin n_errors++; $display("FAIL ar_zero: got %b want 1", out_zero); end
    if (out_carry !== 1'b0) begin n_errors++; $display("FAIL ar_carry: got %b want 0", out_carry); end
    pend_q.delete();
    pend_cyc.delete();
    clear_log();
    step();
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    rand_op();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain(10);
    n_checks += 3;
    if (got_q.size() != 1) begin n_errors++; $display("FAIL ar_post_count: got %0d want 1", got_q.size()); end
    if (got_q[0] !== want_q[0]) begin n_errors++; $display("FAIL ar_post_res: got %h want %h", got_q[0], want_q[0]); end
    if (lat_q[0] != SW) begin n_errors++; $display("FAIL ar_post_lat: got %0d want %0d", lat_q[0], SW); end
  endtask

  task automatic test_flush();
    logic [W-1:0] dval;
    clear_log();
    out_ready = 1'b1;
    rand_op(); in_valid = 1'b1; step();
    rand_op(); step();
    rand_op(); flush = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL fl_in_ready: got %b want 1", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (6) step();
    n_checks++;
    if (got_q.size() != 0) begin n_errors++; $display("FAIL fl_leak: got %0d want 0", got_q.size()); end
    dval = W'($urandom) | 8'h01;
    in_data = dval; in_shift = '0;
    in_dir = 1'($urandom_range(0, 1)); in_mode = 2'($urandom_range(0, 3));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain(10);
    n_checks += 4;
    if (got_q.size() != 1) begin n_errors++; $display("FAIL fl_post_count: got %0d want 1", got_q.size()); end
    if (got_q[0][W-1:0] !== dval) begin n_errors++; $display("FAIL fl_shift0_data: got %h want %h", got_q[0][W-1:0], dval); end
    if (got_q[0][W] !== 1'b0) begin n_errors++; $display("FAIL fl_shift0_carry: got %b want 0", got_q[0][W]); end
    if (lat_q[0] != SW) begin n_errors++; $display("FAIL fl_shift0_lat: got %0d want %0d", lat_q[0], SW); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_async_reset();
    test_flush();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
